// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N one-hot decoder with autonomous scan mode
// Index, dwell counter and decoded lines all update on the same edge, so decoded always matches index.
module scan_decoder #(
  parameter int SEL_W  = 4,
  parameter int DWELL  = 8,
  parameter int INVERT = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                mode_i,
  input  logic                enable_i,
  input  logic                load_i,
  input  logic [SEL_W-1:0]    sel_in_i,
  output logic [2**SEL_W-1:0] decoded_o,
  output logic [SEL_W-1:0]    index_o,
  output logic                wrap_o
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};
  // XOR mask applied to every decoded value, blank included, for active-low boards
  localparam logic [OUT_W-1:0] POL_MASK = (INVERT != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [SEL_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] decoded_q, decoded_d;

  always_comb begin
    index_d = index_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      index_d = sel_in_i;
      cnt_d   = '0;
    end else if (mode_i && enable_i) begin
      if (cnt_q == CNT_LAST) begin
        index_d = index_q + SEL_W'(1);
        cnt_d   = '0;
        wrap_d  = (index_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!mode_i) begin
      // direct mode keeps the counter cleared so a later scan starts with a full dwell
      cnt_d = '0;
    end
    decoded_d = (enable_i ? (OUT_W'(1) << index_d) : {OUT_W{1'b0}}) ^ POL_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      index_q   <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      decoded_q <= POL_MASK;
    end else begin
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      decoded_q <= decoded_d;
    end
  end

  assign decoded_o = decoded_q;
  assign index_o   = index_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - directed self-checking bench for scan_decoder
// Three instances share stimulus: DWELL=3, DWELL=4, and DWELL=4 with active-low outputs.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset, mode, enable, load;
  logic [3:0] sel_in;

  logic [15:0] dec3, dec4, deci;
  logic [3:0]  idx3, idx4, idxi;
  logic        wrap3, wrap4, wrapi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(4), .DWELL(3), .INVERT(0)) u_d3 (
    .clk_i(clk), .reset_i(reset), .mode_i(mode), .enable_i(enable), .load_i(load),
    .sel_in_i(sel_in), .decoded_o(dec3), .index_o(idx3), .wrap_o(wrap3));

  scan_decoder #(.SEL_W(4), .DWELL(4), .INVERT(0)) u_d4 (
    .clk_i(clk), .reset_i(reset), .mode_i(mode), .enable_i(enable), .load_i(load),
    .sel_in_i(sel_in), .decoded_o(dec4), .index_o(idx4), .wrap_o(wrap4));

  scan_decoder #(.SEL_W(4), .DWELL(4), .INVERT(1)) u_inv (
    .clk_i(clk), .reset_i(reset), .mode_i(mode), .enable_i(enable), .load_i(load),
    .sel_in_i(sel_in), .decoded_o(deci), .index_o(idxi), .wrap_o(wrapi));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan();
    reset = 1'b1; mode = 1'b1; enable = 1'b1; load = 1'b0; sel_in = 4'h0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; enable = 1'b0; load = 1'b0; sel_in = 4'h0;
    tick();
    checks++;
    if (dec3 !== 16'h0000) begin errors++; $display("FAIL reset_decoded got=%h exp=0000", dec3); end
    checks++;
    if (idx3 !== 4'h0) begin errors++; $display("FAIL reset_index got=%h exp=0", idx3); end
    checks++;
    if (wrap3 !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap3); end
    checks++;
    if (deci !== 16'hFFFF) begin errors++; $display("FAIL reset_inv_decoded got=%h exp=ffff", deci); end
    reset = 1'b0; enable = 1'b1;
    tick();
    checks++;
    if (dec3 !== 16'h0001) begin errors++; $display("FAIL enable_direct got=%h exp=0001", dec3); end
  endtask

  task automatic test_direct_load();
    mode = 1'b0; enable = 1'b1; load = 1'b1; sel_in = 4'b0101;
    tick();
    load = 1'b0; sel_in = 4'h0;
    checks++;
    if (idx3 !== 4'h5) begin errors++; $display("FAIL load_index got=%h exp=5", idx3); end
    checks++;
    if (dec3 !== 16'h0020) begin errors++; $display("FAIL load_decoded got=%h exp=0020", dec3); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (idx3 !== 4'h5 || dec3 !== 16'h0020)
        begin errors++; $display("FAIL load_hold cyc=%0d got=%h/%h exp=5/0020", i, idx3, dec3); end
    end
  endtask

  task automatic test_scan_sweep();
    logic [3:0]  ei;
    logic [15:0] ed;
    logic        ew;
    start_scan();
    for (int c = 1; c <= 48; c++) begin
      tick();
      ei = 4'((c / 3) % 16);
      ed = 16'h0001 << ei;
      ew = (c == 48);
      checks++;
      if (idx3 !== ei || dec3 !== ed || wrap3 !== ew)
        begin errors++; $display("FAIL sweep cyc=%0d got=%h/%h/%b exp=%h/%h/%b", c, idx3, dec3, wrap3, ei, ed, ew); end
    end
    tick();
    checks++;
    if (wrap3 !== 1'b0 || idx3 !== 4'h0) begin errors++; $display("FAIL sweep_wrap_once got=%b/%h exp=0/0", wrap3, idx3); end
  endtask

  task automatic test_blanking();
    start_scan();
    repeat (30) tick();
    checks++;
    if (idx4 !== 4'h7 || dec4 !== 16'h0080) begin errors++; $display("FAIL blank_pre got=%h/%h exp=7/0080", idx4, dec4); end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (idx4 !== 4'h7 || dec4 !== 16'h0000)
        begin errors++; $display("FAIL blank_low cyc=%0d got=%h/%h exp=7/0000", i, idx4, dec4); end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (idx4 !== 4'h7 || dec4 !== 16'h0080) begin errors++; $display("FAIL blank_resume got=%h/%h exp=7/0080", idx4, dec4); end
    tick();
    checks++;
    if (idx4 !== 4'h8 || dec4 !== 16'h0100) begin errors++; $display("FAIL blank_step got=%h/%h exp=8/0100", idx4, dec4); end
  endtask

  task automatic test_collision();
    start_scan();
    repeat (47) tick();
    checks++;
    if (idx3 !== 4'hF) begin errors++; $display("FAIL coll_pre got=%h exp=f", idx3); end
    load = 1'b1; sel_in = 4'hA;
    tick();
    load = 1'b0; sel_in = 4'h0;
    checks++;
    if (idx3 !== 4'hA || dec3 !== 16'h0400 || wrap3 !== 1'b0)
      begin errors++; $display("FAIL coll_load got=%h/%h/%b exp=a/0400/0", idx3, dec3, wrap3); end
    repeat (2) tick();
    checks++;
    if (idx3 !== 4'hA) begin errors++; $display("FAIL coll_dwell got=%h exp=a", idx3); end
    tick();
    checks++;
    if (idx3 !== 4'hB || dec3 !== 16'h0800) begin errors++; $display("FAIL coll_step got=%h/%h exp=b/0800", idx3, dec3); end
  endtask

  task automatic test_inverted_reset();
    start_scan();
    repeat (36) tick();
    checks++;
    if (idxi !== 4'h9 || deci !== 16'hFDFF) begin errors++; $display("FAIL inv_scan got=%h/%h exp=9/fdff", idxi, deci); end
    reset = 1'b1;
    tick();
    checks++;
    if (idxi !== 4'h0 || deci !== 16'hFFFF || wrapi !== 1'b0)
      begin errors++; $display("FAIL inv_reset got=%h/%h/%b exp=0/ffff/0", idxi, deci, wrapi); end
    reset = 1'b0;
    tick();
    checks++;
    if (idxi !== 4'h0 || deci !== 16'hFFFE) begin errors++; $display("FAIL inv_release got=%h/%h exp=0/fffe", idxi, deci); end
  endtask

  initial begin
    test_reset();
    test_direct_load();
    test_scan_sweep();
    test_blanking();
    test_collision();
    test_inverted_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
